// File: rtl/sort_pkg.sv
// rtl/sort_pkg.sv - shared types and sizing helpers for the in-place RAM sorter
package sort_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_A,
    RD_B,
    CMP,
    WR_A,
    WR_B,
    DONE
  } state_t;

  localparam int default_addr_width = 2;
  localparam int default_data_width = 8;

  function automatic int num_entries(input int aw);
    return 1 << aw;
  endfunction

  // N(N-1)/2 swaps always fit in 2*aw bits
  function automatic int swap_count_width(input int aw);
    return 2 * aw;
  endfunction

endpackage

// File: rtl/ram_sorter.sv
// rtl/ram_sorter.sv - bubble sort with early exit over a single-port registered-read RAM
module ram_sorter
  import sort_pkg::*;
#(
  parameter int addr_width = default_addr_width,
  parameter int data_width = default_data_width
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  output logic                          ram_we,
  output logic [addr_width-1:0]         ram_addr,
  output logic [data_width-1:0]         ram_din,
  input  logic [data_width-1:0]         ram_dout,
  output logic [swap_count_width(addr_width)-1:0] swap_count
);

  localparam int sc_width = swap_count_width(addr_width);
  localparam logic [addr_width:0]   one_ext = 1;
  localparam logic [addr_width-1:0] one_a   = 1;
  localparam logic [sc_width-1:0]   one_sc  = 1;

  state_t state, state_d;

  logic [addr_width-1:0] i, limit;
  logic [data_width-1:0] a_q, b_q;
  logic                  swapped;

  logic [addr_width:0] i_inc;
  logic                more;
  logic                less;
  logic                swapped_now;
  logic                adv_en;
  state_t              adv_state;

  assign i_inc       = {1'b0, i} + one_ext;
  assign more        = i_inc < {1'b0, limit};
  assign less        = ram_dout < a_q;
  assign swapped_now = swapped | (state == WR_B);
  assign adv_en      = ((state == CMP) && !less) || (state == WR_B);

  always_comb begin
    adv_state = RD_A;
    if (!more && (!swapped_now || limit == one_a)) adv_state = DONE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (start) state_d = RD_A;
      RD_A:    state_d = RD_B;
      RD_B:    state_d = CMP;
      CMP:     state_d = less ? WR_A : adv_state;
      WR_A:    state_d = WR_B;
      WR_B:    state_d = adv_state;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i          <= '0;
      limit      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      swapped    <= 1'b0;
      swap_count <= '0;
    end else begin
      if (state == IDLE && start) begin
        i          <= '0;
        limit      <= '1;
        swapped    <= 1'b0;
        swap_count <= '0;
      end
      if (state == RD_B) a_q <= ram_dout;
      if (state == CMP)  b_q <= ram_dout;
      if (state == WR_B) begin
        swapped    <= 1'b1;
        swap_count <= swap_count + one_sc;
      end
      // a pass that ends while more work remains restarts from the bottom with a shorter limit
      if (adv_en) begin
        if (more) begin
          i <= i_inc[addr_width-1:0];
        end else if (adv_state == RD_A) begin
          i       <= '0;
          limit   <= limit - one_a;
          swapped <= 1'b0;
        end
      end
    end
  end

  assign busy     = (state != IDLE);
  assign done     = (state == DONE);
  assign ram_we   = (state == WR_A) || (state == WR_B);
  assign ram_addr = ((state == RD_B) || (state == WR_B)) ? i_inc[addr_width-1:0] : i;
  assign ram_din  = (state == WR_A) ? b_q : (state == WR_B) ? a_q : '0;

endmodule

// File: tb/tb_ram_sorter.sv
// tb/tb_ram_sorter.sv - randomized and directed bench for ram_sorter against a plain-array model
module tb_ram_sorter;

  localparam int aw = 2;
  localparam int dw = 8;
  localparam int n  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          busy, done, ram_we;
  logic [aw-1:0] ram_addr;
  logic [dw-1:0] ram_din, ram_dout;
  logic [2*aw-1:0] swap_count;

  logic [dw-1:0] mem [n];
  logic [aw-1:0] addr_q;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ram_sorter #(.addr_width(aw), .data_width(dw)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout), .swap_count(swap_count)
  );

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    addr_q <= ram_addr;
  end
  assign ram_dout = mem[addr_q];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pack(input logic [dw-1:0] v [n]);
    return {v[0], v[1], v[2], v[3]};
  endfunction

  // bubble sort with early exit, costing 3 cycles per compare, 2 more per swap, 1 for DONE
  task automatic model(input logic [dw-1:0] v [n], output logic [dw-1:0] s [n],
                       output int cyc, output int inv);
    logic [dw-1:0] t;
    int lim;
    bit sw;
    s = v;
    cyc = 0;
    inv = 0;
    for (int a = 0; a < n; a++)
      for (int b = a + 1; b < n; b++)
        if (v[a] > v[b]) inv++;
    lim = n - 1;
    forever begin
      sw = 0;
      for (int j = 0; j < lim; j++) begin
        cyc += 3;
        if (s[j+1] < s[j]) begin
          t = s[j]; s[j] = s[j+1]; s[j+1] = t;
          cyc += 2;
          sw = 1;
        end
      end
      if (!sw || lim == 1) break;
      lim--;
    end
    cyc += 1;
  endtask

  task automatic run_sort(input string tag, input logic [dw-1:0] vals [n], input bit repulse);
    logic [dw-1:0] exp_s [n];
    int exp_cyc, inv, cyc, wes, dones;
    bit seen;
    model(vals, exp_s, exp_cyc, inv);
    @(negedge clk);
    for (int k = 0; k < n; k++) mem[k] = vals[k];
    start = 1'b1;
    cyc = 0; wes = 0; dones = 0; seen = 0;
    while (cyc < 400) begin
      @(negedge clk);
      cyc++;
      start = repulse && (cyc == 3);
      if (ram_we) wes++;
      if (!busy) break;
      if (done) begin
        dones++;
        seen = 1;
        start = repulse;
        break;
      end
    end
    check({tag, "_done_seen"}, seen, 1);
    check({tag, "_done_cycle"}, cyc, exp_cyc);
    check({tag, "_swap_count"}, swap_count, inv);
    @(negedge clk);
    start = 1'b0;
    check({tag, "_idle_busy"}, busy, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (done) dones++;
      if (busy) dones += 10;
    end
    check({tag, "_done_pulses"}, dones, 1);
    check({tag, "_writes"}, wes, 2 * inv);
    check({tag, "_ram"}, pack(mem), pack(exp_s));
  endtask

  initial begin
    logic [dw-1:0] v [n];
    int guard;

    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_we", ram_we, 0);
    check("reset_addr", ram_addr, 0);
    check("reset_din", ram_din, 0);
    check("reset_swaps", swap_count, 0);
    rst = 1'b1;

    v = '{8'd1, 8'd2, 8'd3, 8'd4};     run_sort("sorted", v, 0);
    v = '{8'd4, 8'd3, 8'd2, 8'd1};     run_sort("reverse", v, 0);
    v = '{8'd7, 8'd7, 8'd0, 8'd7};     run_sort("dups", v, 0);
    v = '{8'd255, 8'd0, 8'd128, 8'd1}; run_sort("extremes", v, 0);
    v = '{8'd9, 8'd8, 8'd6, 8'd5};     run_sort("repulse", v, 1);
    v = '{8'd2, 8'd1, 8'd3, 8'd4};     run_sort("resort", v, 0);

    for (int r = 0; r < 12; r++) begin
      for (int k = 0; k < n; k++)
        v[k] = (r % 2 == 0) ? dw'($urandom_range(0, 3)) : dw'($urandom);
      run_sort("random", v, r % 3 == 0);
    end

    @(negedge clk);
    v = '{8'd4, 8'd3, 8'd2, 8'd1};
    for (int k = 0; k < n; k++) mem[k] = v[k];
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    guard = 0;
    while (!ram_we && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("rst_reached_wr_a", ram_we, 1);
    #2 rst = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_we", ram_we, 0);
    check("rst_swaps", swap_count, 0);
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < n; k++) v[k] = mem[k];
    run_sort("after_rst", v, 0);
    check("after_rst_sorted", pack(mem), 32'h01020304);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
